// File: rtl/seg_display_pkg.sv
// seg_display_pkg: mode codes, symbol codes, segment patterns and symbol decode for seg_display_mux
package seg_display_pkg;
  localparam logic [1:0] MODE_SYMBOL = 2'd0;
  localparam logic [1:0] MODE_NUMERIC = 2'd1;
  localparam logic [1:0] MODE_OFF = 2'd2;
  localparam logic [31:0] SYM_UP = 32'd10;
  localparam logic [31:0] SYM_DOWN = 32'd11;
  localparam logic [31:0] SYM_LEFT = 32'd12;
  localparam logic [31:0] SYM_RIGHT = 32'd13;
  localparam logic [31:0] SYM_UP_DOWN = 32'd14;
  localparam logic [31:0] SYM_UP_LEFT = 32'd15;
  localparam logic [31:0] SYM_UP_RIGHT = 32'd16;
  localparam logic [31:0] SYM_DOWN_LEFT = 32'd17;
  localparam logic [31:0] SYM_DOWN_RIGHT = 32'd18;
  localparam logic [31:0] SYM_LEFT_RIGHT = 32'd19;
  localparam logic [31:0] SYM_NONE = 32'd20;
  localparam logic [6:0] SEG_UP = 7'b1111110;
  localparam logic [6:0] SEG_DOWN = 7'b1110111;
  localparam logic [6:0] SEG_LEFT = 7'b1001111;
  localparam logic [6:0] SEG_RIGHT = 7'b1111001;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} conv_state_e;
  function automatic logic [6:0] sym2seg(input logic [31:0] c);
    case (c)
      32'd0: return 7'b1000000;
      32'd1: return 7'b1111001;
      32'd2: return 7'b0100100;
      32'd3: return 7'b0110000;
      32'd4: return 7'b0011001;
      32'd5: return 7'b0010010;
      32'd6: return 7'b0000010;
      32'd7: return 7'b1111000;
      32'd8: return 7'b0000000;
      32'd9: return 7'b0011000;
      SYM_UP: return SEG_UP;
      SYM_DOWN: return SEG_DOWN;
      SYM_LEFT: return SEG_LEFT;
      SYM_RIGHT: return SEG_RIGHT;
      SYM_UP_DOWN: return SEG_UP & SEG_DOWN;
      SYM_UP_LEFT: return SEG_UP & SEG_LEFT;
      SYM_UP_RIGHT: return SEG_UP & SEG_RIGHT;
      SYM_DOWN_LEFT: return SEG_DOWN & SEG_LEFT;
      SYM_DOWN_RIGHT: return SEG_DOWN & SEG_RIGHT;
      SYM_LEFT_RIGHT: return SEG_LEFT & SEG_RIGHT;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, one add-3/shift per cycle, result valid while done
module bin2bcd_seq
  import seg_display_pkg::*;
#(
  parameter int VALUE_BITS = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [VALUE_BITS-1:0]     bin,
  output logic                      busy,
  output logic                      done,
  output logic [4*NUM_DIGITS-1:0]   bcd,
  output logic                      overflow
);
  localparam int CW = $clog2(VALUE_BITS);
  conv_state_e state_q, state_d;
  logic [VALUE_BITS-1:0] sh_q, sh_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end
  // a one shifted out of the top digit means the value needs more digits than we have
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    state_d = state_q;
    sh_d = sh_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    carry = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SHIFT;
        sh_d = bin;
        bcd_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
      end
      ST_SHIFT: begin
        {carry, bcd_d} = {adj, sh_q[VALUE_BITS-1]};
        ovf_d = ovf_q | carry;
        sh_d = sh_q << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(VALUE_BITS-1) ? ST_DONE : ST_SHIFT;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  assign bcd = bcd_q;
  assign overflow = ovf_q;
endmodule

// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed common-anode 7-segment driver with beat-latched symbols and BCD numeric display
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_BITS = 14,
  parameter int SYMBOL_BITS = 5,
  parameter int REFRESH_DIV = 16,
  parameter int BLANK_LEADING = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              metronome_clk,
  input  logic [1:0]                        mode,
  input  logic [NUM_DIGITS*SYMBOL_BITS-1:0] symbols,
  input  logic [VALUE_BITS-1:0]             value,
  input  logic                              value_load,
  output logic                              busy,
  output logic                              overflow,
  output logic [6:0]                        seg,
  output logic [NUM_DIGITS-1:0]             an
);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  logic [2:0] sync_q;
  logic beat, done, ovf_w, ovf_q, lz;
  logic [NUM_DIGITS*SYMBOL_BITS-1:0] sym_q;
  logic [4*NUM_DIGITS-1:0] bcd_w, bcd_q;
  logic [RW-1:0] ref_q, ref_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [3:0] dig;
  bin2bcd_seq #(.VALUE_BITS(VALUE_BITS), .NUM_DIGITS(NUM_DIGITS)) u_conv (
    .clk(clk), .rst(rst), .start(value_load), .bin(value),
    .busy(busy), .done(done), .bcd(bcd_w), .overflow(ovf_w)
  );
  assign beat = sync_q[1] & ~sync_q[2];
  always_comb begin
    ref_d = ref_q == RW'(REFRESH_DIV-1) ? '0 : ref_q + 1'b1;
    idx_d = ref_q != RW'(REFRESH_DIV-1) ? idx_q : idx_q == IW'(NUM_DIGITS-1) ? '0 : idx_q + 1'b1;
    dig = bcd_q[4*idx_q +: 4];
    lz = BLANK_LEADING != 0 && idx_q != '0 && (bcd_q >> {idx_q, 2'b00}) == '0;
    seg_d = mode == MODE_SYMBOL ? sym2seg(32'(sym_q[idx_q*SYMBOL_BITS +: SYMBOL_BITS])) :
            mode == MODE_NUMERIC ? (ovf_q ? SEG_DASH : lz ? SEG_BLANK : sym2seg(32'(dig))) : SEG_BLANK;
    an_d = mode[1] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      sym_q <= {NUM_DIGITS{SYMBOL_BITS'(SYM_NONE)}};
      bcd_q <= '0;
      ovf_q <= 1'b0;
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q <= '1;
    end else begin
      sync_q <= {sync_q[1:0], metronome_clk};
      if (beat && mode == MODE_SYMBOL) sym_q <= symbols;
      if (done) begin
        bcd_q <= bcd_w;
        ovf_q <= ovf_w;
      end
      ref_q <= ref_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q <= an_d;
    end
  end
  assign overflow = ovf_q;
  assign seg = seg_q;
  assign an = an_q;
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed self-checking bench for seg_display_mux with a 4-cycle refresh slot
module tb_seg_display_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic metronome_clk = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [19:0] symbols = '0;
  logic [13:0] value = '0;
  logic value_load = 1'b0;
  logic busy, overflow;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0;
  int failures = 0;
  int n;
  seg_display_mux #(.NUM_DIGITS(4), .VALUE_BITS(14), .SYMBOL_BITS(5), .REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
    .clk(clk), .rst(rst), .metronome_clk(metronome_clk), .mode(mode), .symbols(symbols),
    .value(value), .value_load(value_load), .busy(busy), .overflow(overflow), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_digit(input int i, input logic [6:0] exp, input string tag);
    int k = 0;
    logic [3:0] want;
    want = ~(4'b0001 << i);
    while (an !== want && k < 64) begin
      @(negedge clk);
      k++;
    end
    if (an !== want) begin
      checks++;
      failures++;
      $error("FAIL %s_scan_timeout observed=%h expected=%h", tag, an, want);
    end else chk(32'(seg), 32'(exp), tag);
  endtask
  task automatic load(input logic [13:0] v);
    @(negedge clk);
    value = v;
    value_load = 1'b1;
    @(negedge clk);
    value_load = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(32'(busy), 32'd0, tag);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk(32'(an), 32'hF, "reset_an");
    chk(32'(seg), 32'h7F, "reset_seg");
    chk(32'(busy), 32'd0, "reset_busy");
    chk(32'(overflow), 32'd0, "reset_ovf");
    symbols = {5'd10, 5'd11, 5'd12, 5'd20};
    rst = 1'b0;
    for (int i = 0; i < 4; i++) check_digit(i, 7'h7F, "sym_none_no_beat");
    metronome_clk = 1'b1;
    repeat (4) @(negedge clk);
    check_digit(3, 7'b1111110, "sym_up");
    check_digit(2, 7'b1110111, "sym_down");
    check_digit(1, 7'b1001111, "sym_left");
    check_digit(0, 7'h7F, "sym_none");
    symbols = {5'd0, 5'd1, 5'd2, 5'd3};
    repeat (3) @(negedge clk);
    check_digit(3, 7'b1111110, "sym_hold_no_beat");
    metronome_clk = 1'b0;
    mode = 2'd1;
    repeat (3) @(negedge clk);
    metronome_clk = 1'b1;
    repeat (5) @(negedge clk);
    metronome_clk = 1'b0;
    mode = 2'd0;
    check_digit(3, 7'b1111110, "sym_beat_in_numeric_ignored");
    mode = 2'd2;
    @(negedge clk);
    chk(32'(an), 32'hF, "off_an");
    chk(32'(seg), 32'h7F, "off_seg");
    mode = 2'd1;
    load(14'd1234);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(32'(n), 32'd15, "busy_cycles");
    chk(32'(overflow), 32'd0, "ovf_1234");
    @(negedge clk);
    n = 0;
    while (an == 4'b1110 && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (an != 4'b1110 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(32'({an, seg}), 32'({4'b1110, 7'b0011001}), "scan_d0_4");
    repeat (4) @(negedge clk);
    chk(32'({an, seg}), 32'({4'b1101, 7'b0110000}), "scan_d1_3");
    repeat (4) @(negedge clk);
    chk(32'({an, seg}), 32'({4'b1011, 7'b0100100}), "scan_d2_2");
    repeat (4) @(negedge clk);
    chk(32'({an, seg}), 32'({4'b0111, 7'b1111001}), "scan_d3_1");
    repeat (4) @(negedge clk);
    chk(32'({an, seg}), 32'({4'b1110, 7'b0011001}), "scan_wrap_4");
    load(14'd7);
    wait_idle("idle_7");
    for (int i = 1; i < 4; i++) check_digit(i, 7'h7F, "blank_7");
    check_digit(0, 7'b1111000, "digit_7");
    load(14'd0);
    wait_idle("idle_0");
    check_digit(0, 7'b1000000, "digit_zero");
    check_digit(1, 7'h7F, "blank_zero");
    load(14'd12000);
    wait_idle("idle_12000");
    chk(32'(overflow), 32'd1, "ovf_12000");
    for (int i = 0; i < 4; i++) check_digit(i, 7'b0111111, "dash_12000");
    load(14'd5);
    wait_idle("idle_5");
    chk(32'(overflow), 32'd0, "ovf_cleared");
    check_digit(0, 7'b0010010, "digit_5");
    check_digit(3, 7'h7F, "blank_5");
    load(14'd50);
    repeat (3) @(negedge clk);
    load(14'd99);
    wait_idle("idle_50");
    check_digit(1, 7'b0010010, "ignored_load_tens");
    check_digit(0, 7'b1000000, "ignored_load_units");
    load(14'd77);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(32'(busy), 32'd0, "abort_busy");
    repeat (20) @(negedge clk);
    chk(32'(busy), 32'd0, "abort_no_restart");
    chk(32'(overflow), 32'd0, "abort_ovf");
    check_digit(0, 7'b1000000, "abort_digit0");
    check_digit(1, 7'h7F, "abort_digit1");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
